cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter_pkg.sv | 26 ++
 rtl/cmp_arbiter_rr_pick.sv | 36 +++
 rtl/cmp_arbiter.sv | 130 +++++++++++++
 tb/tb_cmp_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_arbiter_pkg.sv
// Shared constants, FSM encoding and pointer helper for the round-robin
// signed-compare arbiter.
package cmp_arbiter_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 32;
  localparam int ID_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Pointer moves to the slot just after the winner, wrapping at n.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx, input int n);
    logic [ID_W-1:0] nxt;
    if (int'(idx) == n - 1) begin
      nxt = '0;
    end else begin
      nxt = idx + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cmp_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit at or above ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // Scan from farthest offset to nearest so the closest valid bit wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmp_arbiter.sv
// N requesters share one signed comparator; round-robin grant, three-state
// handshake (grant, compute, hold response until accepted).
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic                   resp_lt,
  output logic                   resp_ne
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  nb_q, nb_d;
  logic              resp_lt_q, resp_lt_d;
  logic              resp_ne_q, resp_ne_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;

  logic [N_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [N_REQ-1:0]  ready_int;
  logic [WIDTH-1:0]  a_sel, b_sel;

  logic [WIDTH-1:0]  sum;
  logic              ovf, cmp_lt, cmp_ne;

  rr_pick #(.N(N_REQ), .IW(ID_W)) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Single shared subtractor: A + ~B + 1, signed less-than from overflow.
  assign sum    = a_q + nb_q + WIDTH'(1);
  assign ovf    = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
  assign cmp_lt = ovf ^ sum[WIDTH-1];
  assign cmp_ne = |sum;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    nb_d      = nb_q;
    resp_lt_d = resp_lt_q;
    resp_ne_d = resp_ne_q;
    resp_id_d = resp_id_q;
    ready_int = '0;
    case (state_q)
      ST_IDLE: begin
        ready_int = pick_grant;
        if (pick_any) begin
          a_d     = a_sel;
          nb_d    = ~b_sel;
          id_d    = pick_idx;
          ptr_d   = rr_next(pick_idx, N_REQ);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        resp_lt_d = cmp_lt;
        resp_ne_d = cmp_ne;
        resp_id_d = id_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      a_q       <= '0;
      nb_q      <= '0;
      resp_lt_q <= 1'b0;
      resp_ne_q <= 1'b0;
      resp_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      a_q       <= a_d;
      nb_q      <= nb_d;
      resp_lt_q <= resp_lt_d;
      resp_ne_q <= resp_ne_d;
      resp_id_q <= resp_id_d;
    end
  end

  // No grant may be offered while reset is held, even though state reads IDLE.
  assign req_ready  = reset_n ? ready_int : '0;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_lt    = resp_lt_q;
  assign resp_ne    = resp_ne_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed and randomized bench for cmp_arbiter against a per-requester
// queue model with a signed-compare reference.
module tb_cmp_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int DEPTH = 128;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic           resp_ready;
  logic [2:0]     resp_id;
  logic           resp_lt;
  logic           resp_ne;

  always #5 clock = ~clock;

  cmp_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_lt    (resp_lt),
    .resp_ne    (resp_ne)
  );

  logic [W-1:0] fa [N][DEPTH];
  logic [W-1:0] fb [N][DEPTH];
  int           head [N];
  int           tail [N];
  int           mptr;
  int           pass_cnt  = 0;
  int           total_cnt = 0;
  logic         prev_lt, prev_ne;
  logic [2:0]   prev_id;
  int           won;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    fa[r][tail[r]] = a;
    fb[r][tail[r]] = b;
    tail[r]++;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h8000_0000;
      1:       v = 32'h7FFF_FFFF;
      2:       v = 32'h0000_0000;
      3:       v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  function automatic bit any_pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) p = 1'b1;
    return p;
  endfunction

  task automatic drive_inputs(input logic [N-1:0] ghost);
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i]       = 1'b1;
        req_a[i*W +: W]    = fa[i][head[i]];
        req_b[i*W +: W]    = fb[i][head[i]];
      end else begin
        req_valid[i]       = ghost[i];
        req_a[i*W +: W]    = $urandom;
        req_b[i*W +: W]    = $urandom;
      end
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check({tag, "_resp_lt"}, 64'(resp_lt), 64'(0));
    check({tag, "_resp_ne"}, 64'(resp_ne), 64'(0));
    check({tag, "_resp_id"}, 64'(resp_id), 64'(0));
  endtask

  task automatic check_resp(input string tag, input int w, input logic lt, input logic ne);
    check({tag, "_valid"}, 64'(resp_valid), 64'(1));
    check({tag, "_id"}, 64'(resp_id), 64'(w));
    check({tag, "_lt"}, 64'(resp_lt), 64'(lt));
    check({tag, "_ne"}, 64'(resp_ne), 64'(ne));
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
  endtask

  // Called just after a falling edge with the DUT idle; returns one cycle
  // after the response has been accepted, again just after a falling edge.
  task automatic serve_one(input int hold, input logic [N-1:0] ghost, output int w_out);
    logic [W-1:0] ea, eb;
    logic [N-1:0] oh;
    logic         elt, ene;
    int           w;
    drive_inputs('0);
    #1;
    check("idle_resp_valid", 64'(resp_valid), 64'(0));
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && head[(mptr + k) % N] < tail[(mptr + k) % N]) w = (mptr + k) % N;
    end
    if (w < 0) begin
      check("no_req_ready", 64'(req_ready), 64'(0));
      w_out = -1;
      @(negedge clock);
      return;
    end
    oh    = '0;
    oh[w] = 1'b1;
    check("grant", 64'(req_ready), 64'(oh));
    ea  = fa[w][head[w]];
    eb  = fb[w][head[w]];
    elt = ($signed(ea) < $signed(eb));
    ene = (ea != eb);
    head[w]++;
    mptr  = (w + 1) % N;
    w_out = w;
    @(negedge clock);
    drive_inputs(ghost);
    resp_ready = 1'b1;
    #1;
    check("exec_req_ready", 64'(req_ready), 64'(0));
    check("exec_resp_valid", 64'(resp_valid), 64'(0));
    check("exec_hold_lt", 64'(resp_lt), 64'(prev_lt));
    check("exec_hold_ne", 64'(resp_ne), 64'(prev_ne));
    check("exec_hold_id", 64'(resp_id), 64'(prev_id));
    @(negedge clock);
    resp_ready = (hold == 0);
    #1;
    check_resp("resp", w, elt, ene);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clock);
      resp_ready = (h == hold);
      #1;
      check_resp("resp_stall", w, elt, ene);
    end
    prev_lt = elt;
    prev_ne = ene;
    prev_id = 3'(w);
    @(negedge clock);
  endtask

  initial begin
    logic [N-1:0] gh;
    logic [W-1:0] ra, rb;
    reset_n    = 1'b0;
    resp_ready = 1'b0;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    mptr       = 0;
    prev_lt    = 1'b0;
    prev_ne    = 1'b0;
    prev_id    = '0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end

    repeat (2) @(negedge clock);
    #1;
    check_reset_outs("rst");
    @(negedge clock);
    reset_n = 1'b1;

    serve_one(0, '0, won);

    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push(i, $urandom, $urandom);
    for (int n = 0; n < 12; n++) begin
      serve_one(0, '0, won);
      check("fair_order", 64'(won), 64'(n % 4));
    end

    push(0, 32'd5, 32'd9);
    serve_one(0, '0, won);
    check("single_id", 64'(won), 64'(0));
    check("single_lt", 64'(resp_lt), 64'(1));
    check("single_ne", 64'(resp_ne), 64'(1));

    push(1, 32'h8000_0000, 32'h7FFF_FFFF);
    serve_one(0, '0, won);
    check("ovf_lt", 64'(resp_lt), 64'(1));
    check("ovf_ne", 64'(resp_ne), 64'(1));
    push(1, 32'h7FFF_FFFF, 32'h8000_0000);
    serve_one(0, '0, won);
    check("swap_lt", 64'(resp_lt), 64'(0));
    check("swap_ne", 64'(resp_ne), 64'(1));
    push(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    serve_one(0, '0, won);
    check("eq_lt", 64'(resp_lt), 64'(0));
    check("eq_ne", 64'(resp_ne), 64'(0));

    // Stall five cycles while requester 3 raises then withdraws a request.
    push(2, 32'hFFFF_FFF0, 32'd3);
    serve_one(5, 4'b1000, won);
    check("bp_id", 64'(won), 64'(2));
    push(0, 32'd1, 32'd2);
    push(3, 32'd7, 32'd7);
    serve_one(0, '0, won);
    check("after_withdraw", 64'(won), 64'(3));
    serve_one(0, '0, won);
    check("after_withdraw2", 64'(won), 64'(0));

    // Reset during EXEC of requester 2; requester 3 also pending.
    push(2, 32'hFFFF_FFFD, 32'd7);
    push(3, 32'd1, 32'd1);
    drive_inputs('0);
    #1;
    check("rst_mid_grant", 64'(req_ready), 64'(4'b0100));
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_outs("rst_mid");
    @(negedge clock);
    #1;
    check_reset_outs("rst_mid_hold");
    reset_n = 1'b1;
    mptr    = 0;
    prev_lt = 1'b0;
    prev_ne = 1'b0;
    prev_id = '0;
    serve_one(0, '0, won);
    check("rst_regrant", 64'(won), 64'(2));
    serve_one(0, '0, won);
    check("rst_next", 64'(won), 64'(3));

    for (int t = 0; t < 40; t++) begin
      ra = rand_op();
      rb = ($urandom_range(0, 3) == 0) ? ra : rand_op();
      push($urandom_range(0, N - 1), ra, rb);
      if ($urandom_range(0, 2) != 0) begin
        gh = N'($urandom);
        serve_one($urandom_range(0, 2), gh, won);
      end
    end
    for (int g = 0; g < 200 && any_pending(); g++) begin
      gh = N'($urandom);
      serve_one($urandom_range(0, 2), gh, won);
    end
    check("drained", 64'(any_pending()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
